way_select_decoder: RTL
=======================

// Module: way_select_decoder
// PURPOSE
//  Registered index-to-one-hot decoder for the L2 way arrays. Takes a way index
//  (victim or hit way) over a valid/ready handshake and drives a one-hot way
//  enable for HOLD_CYCLES cycles, so the selected data/tag array is written.
//  Inverse of the way-hit encoder, which maps a way vector back to an index.
// PARAMETERS
//  IDX_W        3   width of the way index
//  NUM_WAYS     8   number of ways, 2..2**IDX_W; indices >= NUM_WAYS are illegal
//  HOLD_CYCLES  1   cycles way_en stays asserted per request, >= 1
// PORTS
//  clk        in   1         clock; all state updates on rising edge
//  reset      in   1         asynchronous, active-high reset
//  req_valid  in   1         request present
//  req_way    in   IDX_W     way index; sampled only on accept
//  req_ready  out  1         block can accept a request this cycle
//  way_en     out  NUM_WAYS  one-hot enable, bit i = way i; registered
//  busy       out  1         1 while way_en is being driven
//  done       out  1         1-cycle pulse in the last drive cycle
//  err        out  1         1-cycle pulse, cycle after an illegal index is accepted
// BEHAVIOUR
//  - Reset (async assert): way_en=0, busy=0, done=0, err=0, state IDLE, hold
//    counter 0, req_ready=0 while reset is high; outputs clear immediately.
//  - Accept = req_valid && req_ready at a rising edge. req_way is sampled only then.
//  - FSM states IDLE and DRIVE:
//    IDLE : req_ready=1. Legal accept -> DRIVE, way_en <= 1 << req_way, counter
//           <= HOLD_CYCLES-1. Illegal accept (req_way >= NUM_WAYS) -> stay IDLE,
//           err=1 next cycle, way_en stays 0.
//    DRIVE: busy=1, way_en held. Counter decrements each cycle. In the cycle with
//           counter==0: done=1, req_ready=1. Accept there -> legal: reload way_en
//           and counter, stay DRIVE (no bubble); illegal: -> IDLE, err=1.
//           No accept -> IDLE, way_en=0.
//  - Latency: legal accept at edge k -> way_en valid cycles k+1..k+HOLD_CYCLES.
//    Sustained throughput is one request per HOLD_CYCLES cycles.
//  - req_valid/req_way changes while req_ready=0 are ignored; no queueing.
//  - way_en has at most one bit set at all times; never X after reset.
//  - Counter width = max(1, $clog2(HOLD_CYCLES)); no wrap, it only counts down to 0.
//  - done and err never assert together.
// TESTING
//  1 Assert reset for 3 cycles, then release -> way_en=0, busy=0, done=0, err=0,
//    req_ready=0 during reset and 1 in the first cycle after release.
//  2 HOLD_CYCLES=1, accept req_way=3 -> way_en=8'h08 for exactly 1 cycle, done=1
//    in the same cycle, then way_en=8'h00.
//  3 HOLD_CYCLES=2, back-to-back accepts of 0 then 7 -> way_en sequence 01,01,80,80,
//    then 00; done high in cycles 2 and 4; no idle cycle between the two requests.
//  4 NUM_WAYS=6, accept req_way=6 -> err=1 for one cycle, way_en stays 0,
//    req_ready stays 1, busy stays 0.
//  5 HOLD_CYCLES=4, accept req_way=5, assert reset in the 2nd drive cycle ->
//    way_en=0 and busy=0 immediately (before the next edge); the next request after
//    release decodes normally.
//  6 HOLD_CYCLES=3, while busy toggle req_valid and change req_way -> way_en stays
//    at the accepted value; only the accept in the done cycle takes effect.

Source files
------------

// File: rtl/way_select_decoder.sv
// Registered way-index to one-hot decoder for the L2 way arrays. A legal index
// drives its way enable for HOLD_CYCLES cycles; an illegal one pulses err.
module way_select_decoder #(
  parameter int IDX_W       = 3,
  parameter int NUM_WAYS    = 8,
  parameter int HOLD_CYCLES = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  input  logic [IDX_W-1:0]    req_way,
  output logic                req_ready,
  output logic [NUM_WAYS-1:0] way_en,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic {IDLE, DRIVE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_WAYS-1:0] way_en_q, way_en_d, way_dec;
  logic                err_q, err_d;
  logic                accept, legal, last;

  // One extra bit so NUM_WAYS == 2**IDX_W is representable.
  assign legal  = {1'b0, req_way} < (IDX_W+1)'(NUM_WAYS);
  assign last   = (state_q == DRIVE) && (cnt_q == '0);
  assign accept = req_valid && req_ready;

  for (genvar i = 0; i < NUM_WAYS; i++) begin : g_dec
    assign way_dec[i] = (req_way == IDX_W'(i));
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    way_en_d = way_en_q;
    err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (legal) begin
            state_d  = DRIVE;
            way_en_d = way_dec;
            cnt_d    = CNT_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      DRIVE: begin
        if (!last) begin
          cnt_d = cnt_q - 1'b1;
        end else if (accept && legal) begin
          // Reload in the done cycle so back-to-back requests have no bubble.
          way_en_d = way_dec;
          cnt_d    = CNT_LOAD;
        end else begin
          state_d  = IDLE;
          way_en_d = '0;
          err_d    = accept;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      way_en_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      way_en_q <= way_en_d;
      err_q    <= err_d;
    end
  end

  assign req_ready = !reset && ((state_q == IDLE) || last);
  assign way_en    = way_en_q;
  assign busy      = (state_q == DRIVE);
  assign done      = last;
  assign err       = err_q;

endmodule
